wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Parameterised N-master round-robin Wishbone arbiter for the memory subsystem.
- Shares one external Wishbone slave port between cache controller ports, DMA and debug masters.
- Grants are held for a whole bus cycle (cyc_i high). A per-grant watchdog returns err to a master whose slave never responds.
- Masters use the same bus signal set as the cache controller's external interface.

Parameters:
- DATA_WIDTH, 128, data bus width in bits.
- ADDR_WIDTH, 32, address width in bits.
- SEL_WIDTH, DATA_WIDTH/8, byte-select width.
- NUM_MASTERS, 3, number of requesting masters; minimum 2.
- TIMEOUT_CYCLES, 255, watchdog limit in stb-without-response cycles; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- wbm_adr_i  in  NUM_MASTERS*ADDR_WIDTH  master addresses, packed; master i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- wbm_dat_i  in  NUM_MASTERS*DATA_WIDTH  master write data, packed.
- wbm_dat_o  out  DATA_WIDTH  read data, broadcast to all masters.
- wbm_we_i  in  NUM_MASTERS  write enables.
- wbm_sel_i  in  NUM_MASTERS*SEL_WIDTH  byte selects, packed.
- wbm_stb_i  in  NUM_MASTERS  strobes.
- wbm_cyc_i  in  NUM_MASTERS  cycle requests.
- wbm_ack_o  out  NUM_MASTERS  per-master ack.
- wbm_err_o  out  NUM_MASTERS  per-master err.
- wbm_rty_o  out  NUM_MASTERS  per-master rty.
- wbs_adr_o  out  ADDR_WIDTH  slave address.
- wbs_dat_o  out  DATA_WIDTH  slave write data.
- wbs_dat_i  in  DATA_WIDTH  slave read data.
- wbs_we_o  out  1  slave write enable.
- wbs_sel_o  out  SEL_WIDTH  slave byte select.
- wbs_stb_o  out  1  slave strobe.
- wbs_cyc_o  out  1  slave cycle.
- wbs_ack_i  in  1  slave ack.
- wbs_err_i  in  1  slave err.
- wbs_rty_i  in  1  slave rty.
- grant_o  out  NUM_MASTERS  one-hot current grant; all zero when idle.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset state: grant = 0, state IDLE, priority pointer ptr = 0, watchdog counter = 0, timeout flag = 0.
- Outputs during and after reset: wbs_cyc_o, wbs_stb_o, wbs_we_o = 0; wbs_sel_o, wbs_adr_o, wbs_dat_o = 0; all wbm_ack_o/err_o/rty_o = 0.
- FSM states: IDLE, GRANTED, TIMEOUT.
- IDLE:
  - If any wbm_cyc_i is high, grant the first requester searching upward from index ptr, wrapping modulo NUM_MASTERS.
  - Grant is registered: slave-side cyc/stb are visible 1 cycle after the request is first seen. Next state GRANTED.
  - No requests: stay IDLE.
- GRANTED:
  - wbs_adr/dat/we/sel/stb_o are combinationally muxed from the granted master. wbs_cyc_o = granted wbm_cyc_i.
  - wbs_ack/err/rty_i are routed only to the granted master; all other masters see 0.
  - wbm_dat_o = wbs_dat_i unconditionally.
  - Exit when the granted master drops cyc: grant clears next edge, ptr <= granted index + 1 (wrap at NUM_MASTERS), state IDLE.
  - Always one idle bubble between grants; the same master never holds the bus across two consecutive cycles without dropping cyc.
- Watchdog:
  - Counter increments each GRANTED cycle with slave stb high and no ack/err/rty. It clears on any response or on grant change.
  - When TIMEOUT_CYCLES is nonzero and the counter reaches TIMEOUT_CYCLES, enter TIMEOUT.
- TIMEOUT (exactly 1 cycle):
  - wbs_cyc_o and wbs_stb_o are forced 0.
  - wbm_err_o of the granted master is 1. A late slave ack in this cycle is discarded.
  - Then grant clears, ptr advances past the offender, state IDLE.
- Simultaneous events:
  - Requests arriving while GRANTED wait; they do not preempt.
  - Slave response coincident with the master dropping cyc: the response is still routed this cycle, then release.
  - Several requesters in IDLE: pointer order decides, so no master waits more than NUM_MASTERS-1 grants.
- Reset mid-transaction: slave cyc/stb drop on the cycle after the reset edge. No ack/err is delivered to the master; ptr returns to 0.
- Counter width: clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.

Test Plan:
- Single master: master 1 raises cyc/stb, adr=0x100, slave acks after 3 cycles -> wbs_cyc_o high 1 cycle after request; wbm_ack_o=3'b010 for 1 cycle; grant_o returns to 0 the cycle after cyc drops.
- Round-robin: masters 0,1,2 hold cyc constantly, each cycle acked immediately and released -> grant sequence 0,1,2,0,1 with one idle cycle between grants.
- No preemption: master 2 granted; master 0 requests mid-cycle -> grant_o stays 3'b100 until master 2 drops cyc, then master 0 is granted.
- Timeout: TIMEOUT_CYCLES=4, slave never responds -> after 4 stb cycles wbm_err_o[granted]=1 for exactly 1 cycle with wbs_cyc_o=0, then IDLE and ptr advances.
- Response routing: slave asserts err for master 1 -> wbm_err_o=3'b010, wbm_ack_o=0; a write of dat 0xDEAD with sel 0x000F appears on wbs_dat_o/wbs_sel_o unchanged.
- Reset mid-cycle: assert rst while master 0 is granted and waiting -> the next cycle wbs_cyc_o=0, grant_o=0, and no ack or err is delivered.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter
//   Round-robin arbiter that shares one Wishbone slave port between
//   NUM_MASTERS masters (cache controller ports, DMA, debug). A grant is
//   held for the whole bus cycle of the winning master. A watchdog returns
//   err to a master whose slave stops responding.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   wbm_*_i / wbm_*_o             packed master-side buses; master i owns
//                                 slice [i*W +: W] of each packed vector
//   wbm_dat_o                     slave read data, broadcast to all masters
//   wbs_*_o / wbs_*_i             single slave-side Wishbone port
//   grant_o                       one-hot current grant, zero when idle
module wb_rr_arbiter #(
  parameter int DATA_WIDTH     = 128,
  parameter int ADDR_WIDTH     = 32,
  parameter int SEL_WIDTH      = DATA_WIDTH / 8,
  parameter int NUM_MASTERS    = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] wbm_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] wbm_dat_i,
  output logic [DATA_WIDTH-1:0]             wbm_dat_o,
  input  logic [NUM_MASTERS-1:0]            wbm_we_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]            wbm_stb_i,
  input  logic [NUM_MASTERS-1:0]            wbm_cyc_i,
  output logic [NUM_MASTERS-1:0]            wbm_ack_o,
  output logic [NUM_MASTERS-1:0]            wbm_err_o,
  output logic [NUM_MASTERS-1:0]            wbm_rty_o,
  output logic [ADDR_WIDTH-1:0]             wbs_adr_o,
  output logic [DATA_WIDTH-1:0]             wbs_dat_o,
  input  logic [DATA_WIDTH-1:0]             wbs_dat_i,
  output logic                              wbs_we_o,
  output logic [SEL_WIDTH-1:0]              wbs_sel_o,
  output logic                              wbs_stb_o,
  output logic                              wbs_cyc_o,
  input  logic                              wbs_ack_i,
  input  logic                              wbs_err_i,
  input  logic                              wbs_rty_i,
  output logic [NUM_MASTERS-1:0]            grant_o
);

  localparam int IW = $clog2(NUM_MASTERS);
  // A zero limit disables the watchdog; keep a 1-bit counter so widths stay legal.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, GRANTED, TIMEOUT} state_t;

  state_t                 state;
  logic [NUM_MASTERS-1:0] grant;
  logic [IW-1:0]          gidx;
  logic [IW-1:0]          ptr;
  logic [IW-1:0]          next_ptr;
  logic [CW-1:0]          wd_cnt;

  logic                   req_found;
  logic [IW-1:0]          req_idx;
  logic                   slave_resp;
  logic                   wd_hit;

  assign grant_o    = grant;
  assign wbm_dat_o  = wbs_dat_i;
  assign slave_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign next_ptr   = (gidx == IW'(NUM_MASTERS - 1)) ? '0 : gidx + 1'b1;
  // Fires on the stall cycle that brings the counter up to the limit.
  assign wd_hit     = (TIMEOUT_CYCLES != 0) && ((int'(wd_cnt) + 1) >= TIMEOUT_CYCLES);

  // First requester at or above ptr, wrapping around.
  always_comb begin
    int cand;
    cand      = 0;
    req_found = 1'b0;
    req_idx   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = (int'(ptr) + k) % NUM_MASTERS;
      if (!req_found && wbm_cyc_i[cand]) begin
        req_found = 1'b1;
        req_idx   = IW'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      gidx   <= '0;
      ptr    <= '0;
      wd_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (req_found) begin
            grant <= ONE_HOT0 << req_idx;
            gidx  <= req_idx;
            state <= GRANTED;
          end
        end
        GRANTED: begin
          if (!wbm_cyc_i[gidx]) begin
            // Release always wins; a response in this cycle was already routed.
            grant  <= '0;
            ptr    <= next_ptr;
            wd_cnt <= '0;
            state  <= IDLE;
          end else if (slave_resp) begin
            wd_cnt <= '0;
          end else if (wbm_stb_i[gidx]) begin
            if (wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
            if (wd_hit) state <= TIMEOUT;
          end
        end
        TIMEOUT: begin
          grant  <= '0;
          ptr    <= next_ptr;
          wd_cnt <= '0;
          state  <= IDLE;
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Bus outputs are held at zero while rst is high so nothing leaks out of
  // a cycle that is being torn down.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cyc_o = 1'b0;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    if (!rst && state == GRANTED) begin
      wbs_adr_o = wbm_adr_i[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
      wbs_dat_o = wbm_dat_i[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
      wbs_sel_o = wbm_sel_i[int'(gidx)*SEL_WIDTH +: SEL_WIDTH];
      wbs_we_o  = wbm_we_i[gidx];
      wbs_stb_o = wbm_stb_i[gidx];
      wbs_cyc_o = wbm_cyc_i[gidx];
      wbm_ack_o = grant & {NUM_MASTERS{wbs_ack_i}};
      wbm_err_o = grant & {NUM_MASTERS{wbs_err_i}};
      wbm_rty_o = grant & {NUM_MASTERS{wbs_rty_i}};
    end else if (!rst && state == TIMEOUT) begin
      // Slave side is dropped; any late slave response is ignored.
      wbm_err_o = grant;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter
//   Directed self-checking bench for wb_rr_arbiter (3 masters, watchdog
//   limit 4). Inputs change 1 time unit after each rising edge; outputs are
//   compared 2 units later, well away from the next edge.
module tb_wb_rr_arbiter;

  localparam int DW = 128;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam int N  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*AW-1:0] wbm_adr_i;
  logic [N*DW-1:0] wbm_dat_i;
  logic [DW-1:0]   wbm_dat_o;
  logic [N-1:0]    wbm_we_i;
  logic [N*SW-1:0] wbm_sel_i;
  logic [N-1:0]    wbm_stb_i;
  logic [N-1:0]    wbm_cyc_i;
  logic [N-1:0]    wbm_ack_o;
  logic [N-1:0]    wbm_err_o;
  logic [N-1:0]    wbm_rty_o;
  logic [AW-1:0]   wbs_adr_o;
  logic [DW-1:0]   wbs_dat_o;
  logic [DW-1:0]   wbs_dat_i;
  logic            wbs_we_o;
  logic [SW-1:0]   wbs_sel_o;
  logic            wbs_stb_o;
  logic            wbs_cyc_o;
  logic            wbs_ack_i;
  logic            wbs_err_i;
  logic            wbs_rty_i;
  logic [N-1:0]    grant_o;

  int checks   = 0;
  int failures = 0;

  wb_rr_arbiter #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .SEL_WIDTH     (SW),
    .NUM_MASTERS   (N),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wbm_adr_i(wbm_adr_i),
    .wbm_dat_i(wbm_dat_i),
    .wbm_dat_o(wbm_dat_o),
    .wbm_we_i (wbm_we_i),
    .wbm_sel_i(wbm_sel_i),
    .wbm_stb_i(wbm_stb_i),
    .wbm_cyc_i(wbm_cyc_i),
    .wbm_ack_o(wbm_ack_o),
    .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o),
    .wbs_dat_o(wbs_dat_o),
    .wbs_dat_i(wbs_dat_i),
    .wbs_we_o (wbs_we_o),
    .wbs_sel_o(wbs_sel_o),
    .wbs_stb_o(wbs_stb_o),
    .wbs_cyc_o(wbs_cyc_o),
    .wbs_ack_i(wbs_ack_i),
    .wbs_err_i(wbs_err_i),
    .wbs_rty_i(wbs_rty_i),
    .grant_o  (grant_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [N-1:0] rr_exp [5];
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};

    rst       = 1'b1;
    wbm_adr_i = '0;
    wbm_dat_i = '0;
    wbm_we_i  = '0;
    wbm_sel_i = '0;
    wbm_stb_i = '0;
    wbm_cyc_i = '0;
    wbs_dat_i = 128'h1234_5678;
    wbs_ack_i = 1'b0;
    wbs_err_i = 1'b0;
    wbs_rty_i = 1'b0;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    #2;
    checkOutput("rst_grant", grant_o, 0);
    checkOutput("rst_cyc", wbs_cyc_o, 0);
    checkOutput("rst_stb", wbs_stb_o, 0);
    checkOutput("rst_ack", wbm_ack_o, 0);
    checkOutput("rst_adr", wbs_adr_o, 0);
    checkOutput("dat_broadcast", wbm_dat_o, 128'h1234_5678);

    // Single master 1, slave acks after 3 wait cycles
    wbm_adr_i[1*AW +: AW] = 32'h100;
    wbm_cyc_i = 3'b010;
    wbm_stb_i = 3'b010;
    #2;
    checkOutput("t1_cyc_before_grant", wbs_cyc_o, 0);
    tick(); #2;
    checkOutput("t1_grant", grant_o, 3'b010);
    checkOutput("t1_cyc", wbs_cyc_o, 1);
    checkOutput("t1_stb", wbs_stb_o, 1);
    checkOutput("t1_adr", wbs_adr_o, 32'h100);
    tick();
    tick(); #2;
    checkOutput("t1_ack_wait", wbm_ack_o, 0);
    tick();
    wbs_ack_i = 1'b1;
    #2;
    checkOutput("t1_ack", wbm_ack_o, 3'b010);
    tick();
    wbs_ack_i = 1'b0;
    wbm_cyc_i = 3'b000;
    wbm_stb_i = 3'b000;
    #2;
    checkOutput("t1_ack_gone", wbm_ack_o, 0);
    checkOutput("t1_grant_held", grant_o, 3'b010);
    tick(); #2;
    checkOutput("t1_grant_clear", grant_o, 0);

    // Error routing with a write from master 1 (released on the err cycle)
    wbm_dat_i[1*DW +: DW]  = 128'hDEAD;
    wbm_sel_i[1*SW +: SW]  = 16'h000F;
    wbm_we_i  = 3'b010;
    wbm_cyc_i = 3'b010;
    wbm_stb_i = 3'b010;
    tick(); #2;
    checkOutput("t2_grant", grant_o, 3'b010);
    checkOutput("t2_dat", wbs_dat_o, 128'hDEAD);
    checkOutput("t2_sel", wbs_sel_o, 16'h000F);
    checkOutput("t2_we", wbs_we_o, 1);
    tick();
    wbs_err_i = 1'b1;
    wbm_cyc_i = 3'b000;
    wbm_stb_i = 3'b000;
    #2;
    checkOutput("t2_err", wbm_err_o, 3'b010);
    checkOutput("t2_no_ack", wbm_ack_o, 0);
    tick();
    wbs_err_i = 1'b0;
    wbm_we_i  = 3'b000;
    #2;
    checkOutput("t2_grant_clear", grant_o, 0);
    checkOutput("t2_err_gone", wbm_err_o, 0);

    // Reset while master 0 is waiting (ptr is 2, so master 0 wins by wrap)
    wbm_cyc_i = 3'b001;
    wbm_stb_i = 3'b001;
    tick(); #2;
    checkOutput("t3_grant_wrap", grant_o, 3'b001);
    tick(); #2;
    checkOutput("t3_cyc_waiting", wbs_cyc_o, 1);
    rst       = 1'b1;
    wbs_ack_i = 1'b1;
    #2;
    checkOutput("t3_ack_in_reset", wbm_ack_o, 0);
    tick(); #2;
    checkOutput("t3_grant", grant_o, 0);
    checkOutput("t3_cyc", wbs_cyc_o, 0);
    checkOutput("t3_err", wbm_err_o, 0);
    checkOutput("t3_ack", wbm_ack_o, 0);
    rst       = 1'b0;
    wbs_ack_i = 1'b0;
    wbm_cyc_i = 3'b000;
    wbm_stb_i = 3'b000;
    tick();

    // Round-robin: all masters request, immediate ack and release
    wbm_cyc_i = 3'b111;
    wbm_stb_i = 3'b111;
    for (int i = 0; i < 5; i++) begin
      tick(); #2;
      checkOutput($sformatf("rr%0d_grant", i), grant_o, rr_exp[i]);
      wbs_ack_i = 1'b1;
      wbm_cyc_i = 3'b111 & ~rr_exp[i];
      wbm_stb_i = 3'b111 & ~rr_exp[i];
      #2;
      checkOutput($sformatf("rr%0d_ack", i), wbm_ack_o, rr_exp[i]);
      tick();
      wbs_ack_i = 1'b0;
      wbm_cyc_i = 3'b111;
      wbm_stb_i = 3'b111;
      #2;
      checkOutput($sformatf("rr%0d_bubble", i), grant_o, 0);
      checkOutput($sformatf("rr%0d_bubble_cyc", i), wbs_cyc_o, 0);
    end

    // No preemption: master 2 holds the bus while master 0 requests
    wbm_cyc_i = 3'b100;
    wbm_stb_i = 3'b100;
    tick(); #2;
    checkOutput("t4_grant2", grant_o, 3'b100);
    wbm_cyc_i = 3'b101;
    wbm_stb_i = 3'b101;
    tick(); #2;
    checkOutput("t4_hold_a", grant_o, 3'b100);
    tick(); #2;
    checkOutput("t4_hold_b", grant_o, 3'b100);
    wbm_cyc_i = 3'b001;
    wbm_stb_i = 3'b001;
    #2;
    checkOutput("t4_hold_drop", grant_o, 3'b100);
    tick(); #2;
    checkOutput("t4_bubble", grant_o, 0);
    tick(); #2;
    checkOutput("t4_grant0", grant_o, 3'b001);

    // Watchdog: master 0 strobes, slave never answers
    tick(); #2;
    checkOutput("t5_no_err_2", wbm_err_o, 0);
    tick();
    tick(); #2;
    checkOutput("t5_cyc_4", wbs_cyc_o, 1);
    checkOutput("t5_no_err_4", wbm_err_o, 0);
    tick();
    wbs_ack_i = 1'b1;
    #2;
    checkOutput("t5_err", wbm_err_o, 3'b001);
    checkOutput("t5_late_ack", wbm_ack_o, 0);
    checkOutput("t5_cyc", wbs_cyc_o, 0);
    checkOutput("t5_stb", wbs_stb_o, 0);
    tick();
    wbs_ack_i = 1'b0;
    wbm_cyc_i = 3'b101;
    wbm_stb_i = 3'b101;
    #2;
    checkOutput("t5_err_gone", wbm_err_o, 0);
    checkOutput("t5_idle", grant_o, 0);
    tick(); #2;
    checkOutput("t5_ptr_advanced", grant_o, 3'b100);

    wbm_cyc_i = 3'b000;
    wbm_stb_i = 3'b000;
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
